// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running column/line counters with registered sync, blanking and position outputs.
// Outputs reflect the position held before each enabled edge; everything freezes while en is low.
module vga_timing_gen #(
  parameter int H_ACTIVE           = 640,
  parameter int H_FRONT_PORCH      = 16,
  parameter int HSYNC_PULSE_CYCLES = 96,
  parameter int H_BACK_PORCH       = 48,
  parameter int V_ACTIVE_LINES     = 480,
  parameter int V_FRONT_LINES      = 10,
  parameter int VSYNC_LINES        = 2,
  parameter int V_BACK_LINES       = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       data,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + HSYNC_PULSE_CYCLES + H_BACK_PORCH;
  localparam int V_TOTAL = V_ACTIVE_LINES + V_FRONT_LINES + VSYNC_LINES + V_BACK_LINES;

  // Counters never narrower than the 10-bit position outputs.
  localparam int HCW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
  localparam int VCW = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;

  localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT      = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] H_SYNC_BEG = HCW'(H_ACTIVE + H_FRONT_PORCH);
  localparam logic [HCW-1:0] H_SYNC_END = HCW'(H_ACTIVE + H_FRONT_PORCH + HSYNC_PULSE_CYCLES);

  localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT      = VCW'(V_ACTIVE_LINES);
  localparam logic [VCW-1:0] V_SYNC_BEG = VCW'(V_ACTIVE_LINES + V_FRONT_LINES);
  localparam logic [VCW-1:0] V_SYNC_END = VCW'(V_ACTIVE_LINES + V_FRONT_LINES + VSYNC_LINES);

  logic [HCW-1:0] hc;
  logic [VCW-1:0] vc;
  logic           h_wrap;

  assign h_wrap = (hc == H_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (en) begin
      if (h_wrap) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // Decode the pre-increment position, so outputs trail the counters by one enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      data        <= 1'b0;
      col         <= '0;
      row         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hsync       <= !((hc >= H_SYNC_BEG) && (hc < H_SYNC_END));
      vsync       <= !((vc >= V_SYNC_BEG) && (vc < V_SYNC_END));
      data        <= (hc < H_ACT) && (vc < V_ACT);
      col         <= 10'(hc);
      row         <= 10'(vc);
      line_start  <= (hc == '0);
      frame_start <= (hc == '0) && (vc == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line.
- H_FRONT_PORCH, 16, blank cycles after active video, before hsync.
- HSYNC_PULSE_CYCLES, 96, hsync low width in cycles.
- H_BACK_PORCH, 48, blank cycles after hsync, before the next active video.
- V_ACTIVE_LINES, 480, visible lines per frame.
- V_FRONT_LINES, 10, blank lines after active lines.
- VSYNC_LINES, 2, vsync low width in lines.
- V_BACK_LINES, 33, blank lines after vsync.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock for the whole block.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, pixel enable; state advances only when en=1.
- hsync, output, 1, horizontal sync, active low.
- vsync, output, 1, vertical sync, active low.
- data, output, 1, high during active video.
- col, output, 10, current pixel column.
- row, output, 10, current line.
- line_start, output, 1, one-cycle pulse at column 0 of every line.
- frame_start, output, 1, one-cycle pulse at (col 0, row 0).

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FRONT_PORCH+HSYNC_PULSE_CYCLES+H_BACK_PORCH (default 800), and V_TOTAL SHALL equal the sum of the four V parameters (default 525).
REQ-004 Internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1) SHALL be sized from the parameters, with at least 10 bits each at the defaults.
REQ-005 On each clk edge with en=1, hc SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vc SHALL increment; when hc=H_TOTAL-1 and vc=V_TOTAL-1, both SHALL wrap to 0.
REQ-006 On each clk edge with en=1, all outputs SHALL register the decode of the pre-increment (hc,vc); output latency is therefore one enabled cycle.
REQ-007 With en=0, the counters and all outputs SHALL hold their values; line_start and frame_start SHALL be 0 on any edge where en=0.
REQ-008 The registered data value SHALL be 1 iff hc<H_ACTIVE and vc<V_ACTIVE_LINES.
REQ-009 The registered hsync value SHALL be 0 iff H_ACTIVE+H_FRONT_PORCH <= hc < H_ACTIVE+H_FRONT_PORCH+HSYNC_PULSE_CYCLES (default 656..751), on every line including vertical blanking.
REQ-010 The registered vsync value SHALL be 0 for whole lines where V_ACTIVE_LINES+V_FRONT_LINES <= vc < V_ACTIVE_LINES+V_FRONT_LINES+VSYNC_LINES (default 490..491); at en=1 every cycle this gives VSYNC_LINES*H_TOTAL = 1600 cycles low.
REQ-011 The registered col and row values SHALL equal hc and vc, and SHALL count through the blanking regions.
REQ-012 The registered line_start value SHALL be 1 iff hc=0; the registered frame_start value SHALL be 1 iff hc=0 and vc=0.
REQ-013 Horizontal order within a line SHALL be: active, front porch, sync, back porch.
REQ-014 Vertical order within a frame SHALL be: active lines, front lines, sync lines, back lines.
REQ-015 At en=1 every cycle, the output streams SHALL satisfy the downstream timing-check stage exactly:
- data low to hsync falling = H_FRONT_PORCH cycles;
- hsync low = HSYNC_PULSE_CYCLES cycles;
- data low to data rising = front porch + sync + back porch cycles on active lines;
- vsync low = 1600 cycles.

Reset
REQ-016 While rst_n=0, regardless of clk or en:
- hc=0, vc=0;
- hsync=1, vsync=1;
- data=0;
- col=0, row=0;
- line_start=0, frame_start=0.
REQ-017 The first enabled edge after rst_n rises SHALL present position (0,0): data=1, line_start=1, frame_start=1.
REQ-018 Asserting rst_n mid-frame SHALL abort the frame immediately, with no completion of the current line.

Verification
REQ-019 A bench SHALL cover the following directed scenarios.
- Reset release, en=1: first edge gives frame_start=1, data=1, col=0, row=0; data stays 1 for 640 cycles.
- Line timing, en=1: data 1 for 640 cycles, then data=0 with hsync=1 for 16 cycles, hsync=0 for 96, hsync=1 for 48; line_start pulses every 800 cycles.
- Frame timing: vsync falls 490*800 cycles after frame_start, stays low 1600 cycles; the next frame_start follows 420000 cycles after the previous one.
- en toggling (en=1 on every third cycle): per-line output sequence is identical to the en=1 case, counted in enabled cycles; outputs are frozen on en=0 edges; pulses are never asserted on en=0 edges.
- Wrap boundary: at col=799, row=524, the next enabled edge gives col=0, row=0, frame_start=1.
- Mid-frame reset at row 300: outputs go to reset values asynchronously, before the next clk edge; after release, restart at (0,0).
